// File: rtl/sata_regs_pkg.sv
// Shared definitions for the SATA host register bank: register indices,
// the default ID word and the byte-strobe expansion helper.
package sata_regs_pkg;

  localparam int REG_ID       = 0;
  localparam int REG_CTRL     = 1;
  localparam int REG_IRQ_STAT = 2;
  localparam int REG_IRQ_MASK = 3;
  localparam int REG_STATUS   = 4;
  localparam int REG_SCRATCH0 = 5;

  localparam logic [31:0] ID_VALUE_DEFAULT = 32'h5A7A0001;

  // Expand a 4-bit byte strobe into a 32-bit bit mask
  function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
    logic [31:0] mask;
    for (int b = 0; b < 4; b++) begin
      mask[8*b +: 8] = {8{strb[b]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/sata_regs_rdpipe.sv
// Two-stage read pipeline: ren captures the mux output into a latch,
// regen moves the latch into the output register.
module sata_regs_rdpipe (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic        i_ren,
  input  logic        i_regen,
  input  logic [31:0] i_din,
  output logic [31:0] o_dout
);

  logic [31:0] r_latch;
  logic [31:0] r_dout;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_latch <= '0;
      r_dout  <= '0;
    end else begin
      if (i_ren) begin
        r_latch <= i_din;
      end
      if (i_regen) begin
        r_dout <= r_latch;
      end
    end
  end

  assign o_dout = r_dout;

endmodule

// File: rtl/sata_regs_bank.sv
// SATA host register bank behind the AXI-to-BRAM bridge.
// Define SATA_REGS_IRQ_EN to enable the IRQ_STAT/IRQ_MASK interrupt logic.
module sata_regs_bank
  import sata_regs_pkg::*;
#(
  parameter int          REGISTERS_CNT = 20,
  parameter int          ADDR_BITS     = 16,
  parameter logic [31:0] ID_VALUE      = ID_VALUE_DEFAULT
) (
  input  logic                       ACLK,
  input  logic                       ARESETN,
  input  logic [ADDR_BITS-1:0]       bram_waddr,
  input  logic [31:0]                bram_wdata,
  input  logic [3:0]                 bram_wstb,
  input  logic                       bram_wen,
  input  logic [ADDR_BITS-1:0]       bram_raddr,
  input  logic                       bram_ren,
  input  logic                       bram_regen,
  output logic [31:0]                bram_rdata,
  input  logic [31:0]                irq_set,
  input  logic [31:0]                status_in,
  output logic [31:0]                ctrl_out,
  output logic [REGISTERS_CNT*32-1:0] regs_out,
  output logic                       irq
);

  logic [31:0]              r_regs [REGISTERS_CNT];
  logic [31:0]              w_wmask;
  logic [REGISTERS_CNT-1:0] w_wsel;
  logic [31:0]              w_rmux;

  assign w_wmask = strb_to_mask(bram_wstb);

  // Full-width address compare so out-of-range addresses never alias
  always_comb begin
    w_wsel = '0;
    for (int i = 0; i < REGISTERS_CNT; i++) begin
      w_wsel[i] = bram_wen && (bram_waddr == ADDR_BITS'(i));
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < REGISTERS_CNT; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < REGISTERS_CNT; i++) begin
        if (i == REG_ID || i == REG_STATUS) begin
          r_regs[i] <= '0;
`ifdef SATA_REGS_IRQ_EN
        end else if (i == REG_IRQ_STAT) begin
          // Set is OR-ed after the clear so a simultaneous set wins
          r_regs[i] <= (r_regs[i] & ~(w_wsel[i] ? (bram_wdata & w_wmask) : 32'h0))
                       | irq_set;
`endif
        end else if (w_wsel[i]) begin
          r_regs[i] <= (r_regs[i] & ~w_wmask) | (bram_wdata & w_wmask);
        end
      end
    end
  end

`ifdef SATA_REGS_IRQ_EN
  logic r_irq;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= |(r_regs[REG_IRQ_STAT] & r_regs[REG_IRQ_MASK]);
    end
  end

  assign irq = r_irq;
`else
  logic w_unused_irq_set;

  assign w_unused_irq_set = ^irq_set;
  assign irq              = 1'b0;
`endif

  always_comb begin
    w_rmux = '0;
    for (int i = 0; i < REGISTERS_CNT; i++) begin
      if (bram_raddr == ADDR_BITS'(i)) begin
        if (i == REG_ID) begin
          w_rmux = ID_VALUE;
        end else if (i == REG_STATUS) begin
          w_rmux = status_in;
        end else begin
          w_rmux = r_regs[i];
        end
      end
    end
  end

  sata_regs_rdpipe u_rdpipe (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .i_ren   (bram_ren),
    .i_regen (bram_regen),
    .i_din   (w_rmux),
    .o_dout  (bram_rdata)
  );

  for (genvar g = 0; g < REGISTERS_CNT; g++) begin : g_regs_out
    assign regs_out[32*g +: 32] = r_regs[g];
  end

  assign ctrl_out = r_regs[REG_CTRL];

endmodule

// File: tb/tb_sata_regs_bank.sv
// Scoreboard bench for sata_regs_bank: reads push expected data, a monitor
// pops and compares whenever regen moves data onto bram_rdata.
module tb_sata_regs_bank;

  localparam int REGISTERS_CNT = 20;
  localparam int ADDR_BITS     = 16;

  typedef struct {
    logic [31:0] val;
    int          addr;
  } expT;

  logic                        ACLK;
  logic                        ARESETN;
  logic [ADDR_BITS-1:0]        bram_waddr;
  logic [31:0]                 bram_wdata;
  logic [3:0]                  bram_wstb;
  logic                        bram_wen;
  logic [ADDR_BITS-1:0]        bram_raddr;
  logic                        bram_ren;
  logic                        bram_regen;
  logic [31:0]                 bram_rdata;
  logic [31:0]                 irq_set;
  logic [31:0]                 status_in;
  logic [31:0]                 ctrl_out;
  logic [REGISTERS_CNT*32-1:0] regs_out;
  logic                        irq;

  int  testsRun    = 0;
  int  testsFailed = 0;
  bit  pendingRegen = 0;
  expT expQ[$];
  expT expCur;
  logic [REGISTERS_CNT*32-1:0] snapshot;

  sata_regs_bank #(
    .REGISTERS_CNT (REGISTERS_CNT),
    .ADDR_BITS     (ADDR_BITS),
    .ID_VALUE      (32'h5A7A0001)
  ) dut (
    .ACLK       (ACLK),
    .ARESETN    (ARESETN),
    .bram_waddr (bram_waddr),
    .bram_wdata (bram_wdata),
    .bram_wstb  (bram_wstb),
    .bram_wen   (bram_wen),
    .bram_raddr (bram_raddr),
    .bram_ren   (bram_ren),
    .bram_regen (bram_regen),
    .bram_rdata (bram_rdata),
    .irq_set    (irq_set),
    .status_in  (status_in),
    .ctrl_out   (ctrl_out),
    .regs_out   (regs_out),
    .irq        (irq)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  function automatic logic [31:0] getReg(input int n);
    return regs_out[32*n +: 32];
  endfunction

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Drives one cycle at the falling edge; regen follows the previous ren
  task automatic applyStimulus(input logic wr, input logic [15:0] wa, input logic [31:0] wd,
                               input logic [3:0] ws, input logic rd, input logic [15:0] ra,
                               input logic [31:0] rexp, input logic [31:0] irqs);
    expT e;
    @(negedge ACLK);
    bram_wen   = wr;
    bram_waddr = wa;
    bram_wdata = wd;
    bram_wstb  = ws;
    bram_ren   = rd;
    bram_raddr = ra;
    bram_regen = pendingRegen;
    irq_set    = irqs;
    if (rd) begin
      e.val  = rexp;
      e.addr = int'(ra);
      expQ.push_back(e);
    end
    pendingRegen = rd;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 16'h0, 32'h0, 4'h0, 1'b0, 16'h0, 32'h0, 32'h0);
  endtask

  task automatic checkStoredZero(input string nm);
    for (int i = 1; i < REGISTERS_CNT; i++) begin
      if (i != 4) begin
        checkOutput($sformatf("%s_reg%0d", nm, i), getReg(i), 32'h0);
      end
    end
  endtask

  always @(posedge ACLK) begin
    if (bram_regen && ARESETN) begin
      #1;
      if (expQ.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL unexpected_read: got %h, expected no read data", bram_rdata);
      end else begin
        expCur = expQ.pop_front();
        checkOutput($sformatf("read_addr%0d", expCur.addr), bram_rdata, expCur.val);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    ARESETN    = 1'b0;
    bram_waddr = '0;
    bram_wdata = '0;
    bram_wstb  = '0;
    bram_wen   = 1'b0;
    bram_raddr = '0;
    bram_ren   = 1'b0;
    bram_regen = 1'b0;
    irq_set    = '0;
    status_in  = 32'hCAFE0000;
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;

    checkOutput("reset_rdata", bram_rdata, 32'h0);
    checkOutput("reset_irq", {31'h0, irq}, 32'h0);
    checkStoredZero("reset");

    // ID, CTRL and STATUS reads issued back to back
    applyStimulus(1'b0, 16'h0, 32'h0, 4'h0, 1'b1, 16'd0, 32'h5A7A0001, 32'h0);
    applyStimulus(1'b0, 16'h0, 32'h0, 4'h0, 1'b1, 16'd1, 32'h00000000, 32'h0);
    applyStimulus(1'b0, 16'h0, 32'h0, 4'h0, 1'b1, 16'd4, 32'hCAFE0000, 32'h0);
    idle();

    // Partial-strobe write to CTRL
    applyStimulus(1'b1, 16'd1, 32'h11223344, 4'b0101, 1'b0, 16'h0, 32'h0, 32'h0);
    idle();
    checkOutput("ctrl_out_strobe", ctrl_out, 32'h00220044);
    checkOutput("regs_out_ctrl", getReg(1), 32'h00220044);
    applyStimulus(1'b0, 16'h0, 32'h0, 4'h0, 1'b1, 16'd1, 32'h00220044, 32'h0);
    idle();

`ifdef SATA_REGS_IRQ_EN
    applyStimulus(1'b1, 16'd3, 32'h00000008, 4'hF, 1'b0, 16'h0, 32'h0, 32'h0);
    applyStimulus(1'b0, 16'h0, 32'h0, 4'h0, 1'b0, 16'h0, 32'h0, 32'h00000008);
    idle();
    checkOutput("irq_stat_set", getReg(2), 32'h00000008);
    checkOutput("irq_lag", {31'h0, irq}, 32'h0);
    idle();
    checkOutput("irq_asserted", {31'h0, irq}, 32'h1);
    applyStimulus(1'b1, 16'd2, 32'h00000008, 4'hF, 1'b0, 16'h0, 32'h0, 32'h0);
    idle();
    checkOutput("irq_stat_w1c", getReg(2), 32'h0);
    idle();
    checkOutput("irq_deasserted", {31'h0, irq}, 32'h0);
    applyStimulus(1'b1, 16'd2, 32'h00000008, 4'hF, 1'b0, 16'h0, 32'h0, 32'h00000008);
    idle();
    checkOutput("irq_set_wins", getReg(2), 32'h00000008);
    applyStimulus(1'b1, 16'd2, 32'h00000008, 4'hF, 1'b0, 16'h0, 32'h0, 32'h0);
    idle();
`else
    applyStimulus(1'b1, 16'd2, 32'h12345678, 4'hF, 1'b0, 16'h0, 32'h0, 32'hFFFFFFFF);
    applyStimulus(1'b0, 16'h0, 32'h0, 4'h0, 1'b0, 16'h0, 32'h0, 32'hFFFFFFFF);
    checkOutput("reg2_scratch", getReg(2), 32'h12345678);
    applyStimulus(1'b0, 16'h0, 32'h0, 4'h0, 1'b1, 16'd2, 32'h12345678, 32'hFFFFFFFF);
    applyStimulus(1'b0, 16'h0, 32'h0, 4'h0, 1'b0, 16'h0, 32'h0, 32'hFFFFFFFF);
    checkOutput("irq_disabled", {31'h0, irq}, 32'h0);
    idle();
`endif

    // Last valid scratch register
    applyStimulus(1'b1, 16'd19, 32'h0BADF00D, 4'hF, 1'b0, 16'h0, 32'h0, 32'h0);
    applyStimulus(1'b0, 16'h0, 32'h0, 4'h0, 1'b1, 16'd19, 32'h0BADF00D, 32'h0);
    idle();

    // Ignored writes: read-only registers, out of range, high-bit alias
    snapshot = regs_out;
    applyStimulus(1'b1, 16'd0, 32'hDEADBEEF, 4'hF, 1'b0, 16'h0, 32'h0, 32'h0);
    applyStimulus(1'b1, 16'd4, 32'hDEADBEEF, 4'hF, 1'b0, 16'h0, 32'h0, 32'h0);
    applyStimulus(1'b1, 16'd100, 32'hDEADBEEF, 4'hF, 1'b0, 16'h0, 32'h0, 32'h0);
    applyStimulus(1'b1, 16'd20, 32'hDEADBEEF, 4'hF, 1'b0, 16'h0, 32'h0, 32'h0);
    applyStimulus(1'b1, 16'h8001, 32'hDEADBEEF, 4'hF, 1'b0, 16'h0, 32'h0, 32'h0);
    idle();
    for (int i = 1; i < REGISTERS_CNT; i++) begin
      if (i != 4) begin
        checkOutput($sformatf("ignored_write_reg%0d", i), getReg(i), snapshot[32*i +: 32]);
      end
    end
    applyStimulus(1'b0, 16'h0, 32'h0, 4'h0, 1'b1, 16'd100, 32'h0, 32'h0);
    applyStimulus(1'b0, 16'h0, 32'h0, 4'h0, 1'b1, 16'd20, 32'h0, 32'h0);
    applyStimulus(1'b0, 16'h0, 32'h0, 4'h0, 1'b1, 16'h8001, 32'h0, 32'h0);
    idle();

    // Read/write collision on scratch register 5
    applyStimulus(1'b1, 16'd5, 32'hA5A5A5A5, 4'hF, 1'b1, 16'd5, 32'h00000000, 32'h0);
    applyStimulus(1'b0, 16'h0, 32'h0, 4'h0, 1'b1, 16'd5, 32'hA5A5A5A5, 32'h0);
    idle();

    // Reset between ren and regen
    applyStimulus(1'b0, 16'h0, 32'h0, 4'h0, 1'b1, 16'd1, 32'h00000000, 32'h0);
    @(negedge ACLK);
    bram_ren   = 1'b0;
    bram_regen = 1'b0;
    ARESETN    = 1'b0;
    #1;
    checkOutput("midreset_rdata", bram_rdata, 32'h0);
    checkOutput("midreset_ctrl", ctrl_out, 32'h0);
    checkOutput("midreset_irq", {31'h0, irq}, 32'h0);
    checkStoredZero("midreset");
    @(negedge ACLK);
    ARESETN = 1'b1;
    idle();
    idle();
    idle();

    checkOutput("scoreboard_drained", 32'(expQ.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
